riscv_proc_wb_scheduler: RTL
============================

RISCV_PROC_WB_SCHEDULER -- requirements
Module: riscv_proc_wb_scheduler

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 8, consecutive denied-while-valid cycles before a queue is promoted (2..15).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: dmem_resp_val  input  1  data-memory load response present; cannot be stalled.
REQ-005 SHALL have ports: mwbq_deq_val, dwbq_deq_val, fwbq_deq_val  input  1 each  queue head valid.
REQ-006 SHALL have ports: mwbq_deq_rdy, dwbq_deq_rdy, fwbq_deq_rdy  output  1 each  dequeue grant; a transfer occurs on val&rdy.
REQ-007 SHALL have port: sel  output  2  writeback mux select this cycle: 0 dmem/idle, 1 mwbq, 2 dwbq, 3 fwbq.
REQ-008 SHALL have port: wb_val_q  output  1  registered: a writeback was selected last cycle.
REQ-009 SHALL have port: wb_sel_q  output  2  registered copy of sel.
REQ-010 SHALL have port: dmem_issue_stall  output  1  registered request to the pipeline to stop issuing loads.

Function
REQ-011 dmem_resp_val=1 SHALL force sel=0 and all three rdy=0 in that cycle.
REQ-012 With dmem_resp_val=0, at most one rdy SHALL be 1, and only for a queue whose val=1.
REQ-013 Winner SHALL be the highest-ranked valid queue: starving queues outrank non-starving; within each class fixed order mwbq > dwbq > fwbq.
REQ-014 sel SHALL equal the winner's code, or 0 with no winner; sel and rdy are combinational from current inputs and state.
REQ-015 Each queue SHALL own an age counter: increments, saturating at STARVE_LIMIT, when val=1 and not granted; clears to 0 when granted or val=0.
REQ-016 A queue SHALL be starving exactly when its age equals STARVE_LIMIT.
REQ-017 dmem_issue_stall SHALL be 1 in the cycle after any age counter equals STARVE_LIMIT, and 0 in the cycle after none does.
REQ-018 wb_val_q SHALL be registered (dmem_resp_val | any grant); wb_sel_q SHALL be registered sel; latency exactly 1 cycle.
REQ-019 A granted queue that drops val SHALL not be granted; a grant does not persist across cycles.

Reset
REQ-020 reset_n=0 SHALL asynchronously clear all age counters, dmem_issue_stall, wb_val_q, wb_sel_q to 0.
REQ-021 During reset, rdy outputs SHALL follow REQ-011..014 with zeroed state; first post-reset edge uses zeroed counters.
REQ-022 Reset mid-starvation SHALL drop dmem_issue_stall immediately and restart aging from 0.

Configuration
REQ-023 Macro WB_SCHED_AGING_EN SHALL compile in aging: defined -> REQ-013, 015-017 as written.
REQ-024 Without WB_SCHED_AGING_EN: no age counters, pure fixed priority dmem > mwbq > dwbq > fwbq, dmem_issue_stall tied 0.

Structure
REQ-025 Shared package riscv_wb_pkg SHALL hold sel codes (WB_SEL_DMEM=0, WB_SEL_MWBQ=1, WB_SEL_DWBQ=2, WB_SEL_FWBQ=3) and the STARVE_LIMIT default.
REQ-026 Sub-module riscv_proc_wb_age_ctr (saturating counter, starving flag) SHALL be instantiated once per queue.

Verification
REQ-027 All three val=1, dmem_resp_val=0, ages 0 -> mwbq_deq_rdy=1, sel=1; next cycle wb_val_q=1, wb_sel_q=1.
REQ-028 dmem_resp_val=1 with all val=1 -> all rdy=0, sel=0; wb_val_q=1, wb_sel_q=0 next cycle.
REQ-029 mwbq_deq_val and fwbq_deq_val held 1 for 8 cycles, STARVE_LIMIT=8 -> cycle 9 fwbq_deq_rdy=1, sel=3, dmem_issue_stall=1 from cycle 10 until the cycle after the grant.
REQ-030 dmem_resp_val=1 and dwbq_deq_val=1 for 10 cycles -> dwbq age saturates at 8, dmem_issue_stall=1; dmem drops -> dwbq granted, age 0, stall clears next cycle.
REQ-031 reset_n pulsed low mid-cycle while dmem_issue_stall=1 -> stall, wb_val_q, wb_sel_q read 0 immediately, without waiting for clk.
REQ-032 Build without WB_SCHED_AGING_EN, rerun REQ-029 stimulus -> fwbq never granted while mwbq valid; dmem_issue_stall constant 0.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared writeback-scheduler definitions: mux select codes and the default starvation limit.
package riscv_wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_DMEM = 2'd0,
    WB_SEL_MWBQ = 2'd1,
    WB_SEL_DWBQ = 2'd2,
    WB_SEL_FWBQ = 2'd3
  } wb_sel_e;

  localparam int WB_STARVE_LIMIT = 8;
  localparam int WB_AGE_W        = 4;

endpackage

// File: rtl/riscv_proc_wb_age_ctr.sv
// Per-queue saturating age counter; flags the queue as starving once the age reaches LIMIT.
module riscv_proc_wb_age_ctr
  import riscv_wb_pkg::*;
#(
  parameter int LIMIT = WB_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic val,
  input  logic grant,
  output logic starving
);

  localparam logic [WB_AGE_W-1:0] LIM = WB_AGE_W'(LIMIT);

  logic [WB_AGE_W-1:0] age_q;

  assign starving = (age_q == LIM);

  // Age only while the head waits unserved; any service or empty head restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age_q <= '0;
    end else if (!val || grant) begin
      age_q <= '0;
    end else if (!starving) begin
      age_q <= age_q + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_proc_wb_scheduler.sv
// Writeback port arbiter: dmem load responses always win; queues share the remaining slots.
// Optional anti-starvation aging is compiled in with WB_SCHED_AGING_EN.
module riscv_proc_wb_scheduler
  import riscv_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dmem_resp_val,
  input  logic       mwbq_deq_val,
  input  logic       dwbq_deq_val,
  input  logic       fwbq_deq_val,
  output logic       mwbq_deq_rdy,
  output logic       dwbq_deq_rdy,
  output logic       fwbq_deq_rdy,
  output logic [1:0] sel,
  output logic       wb_val_q,
  output logic [1:0] wb_sel_q,
  output logic       dmem_issue_stall
);

  logic [2:0] val_vec;
  logic [2:0] pick_vec;
  logic [2:0] grant_vec;

  assign val_vec = {fwbq_deq_val, dwbq_deq_val, mwbq_deq_val};

`ifdef WB_SCHED_AGING_EN
  logic [2:0] starve_vec;
  logic [2:0] hot_vec;

  for (genvar q = 0; q < 3; q++) begin : g_age
    riscv_proc_wb_age_ctr #(
      .LIMIT(STARVE_LIMIT)
    ) u_age_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .val     (val_vec[q]),
      .grant   (grant_vec[q]),
      .starving(starve_vec[q])
    );
  end

  // Starving valid queues form the upper class; fall back to all valid queues when none starve.
  assign hot_vec  = val_vec & starve_vec;
  assign pick_vec = (hot_vec != 3'b000) ? hot_vec : val_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_issue_stall <= 1'b0;
    end else begin
      dmem_issue_stall <= |starve_vec;
    end
  end
`else
  assign pick_vec         = val_vec;
  assign dmem_issue_stall = 1'b0;
`endif

  always_comb begin
    grant_vec = 3'b000;
    sel       = WB_SEL_DMEM;
    if (!dmem_resp_val) begin
      if (pick_vec[0]) begin
        grant_vec = 3'b001;
        sel       = WB_SEL_MWBQ;
      end else if (pick_vec[1]) begin
        grant_vec = 3'b010;
        sel       = WB_SEL_DWBQ;
      end else if (pick_vec[2]) begin
        grant_vec = 3'b100;
        sel       = WB_SEL_FWBQ;
      end
    end
  end

  assign mwbq_deq_rdy = grant_vec[0];
  assign dwbq_deq_rdy = grant_vec[1];
  assign fwbq_deq_rdy = grant_vec[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_val_q <= 1'b0;
      wb_sel_q <= WB_SEL_DMEM;
    end else begin
      wb_val_q <= dmem_resp_val | (|grant_vec);
      wb_sel_q <= sel;
    end
  end

endmodule
